// File: rtl/alu_pipe_pkg.sv
// Operation list for alu_pipe: opcode encoding, control states and the NZCV flag bundle.
package alu_pipe_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_SLT  = 4'd8,
      OP_SLTU = 4'd9,
      OP_MUL  = 4'd10
   } op_e;

   typedef enum logic {
      IDLE,
      MUL_BUSY
   } alu_state_e;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

   // Codes above OP_MUL have no meaning and retire as illegal.
   function automatic logic op_defined(input logic [3:0] op);
      return op <= OP_MUL;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: bit 0 is folded in on start, one further bit per busy cycle.
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             kill,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic             busy;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;

   // product is the accumulator including this cycle's partial product, so the
   // final bit can be captured downstream on the same edge that clears busy.
   assign product = acc + (mplier[0] ? mcand : '0);
   assign done    = busy && (count == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         count  <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (kill) begin
         busy  <= 1'b0;
         count <= '0;
      end else if (start) begin
         busy   <= 1'b1;
         count  <= CW'(1);
         acc    <= b[0] ? a : '0;
         mcand  <= a << 1;
         mplier <= b >> 1;
      end else if (busy) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (done) begin
            busy  <= 1'b0;
            count <= '0;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result and NZCV flags; single-cycle ops plus iterative MUL.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             illegal
);

   localparam int               SW      = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] WIDTH_V = WIDTH;

   alu_state_e       state_q, state_d;
   logic             accept;
   logic             is_mul;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;
   alu_flags_t       flags_q;

   logic [WIDTH-1:0] sc_result;
   alu_flags_t       sc_flags;
   logic             sc_illegal;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] b_eff;
   logic [SW-1:0]    shamt;
   logic             is_sub;

   assign is_mul = MUL_EN && (op == OP_MUL);

   // NOTE: every signal written here gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      in_ready = (state_q == IDLE) && (!out_valid || out_ready) && !flush;
      accept   = in_valid && in_ready;
      state_d  = state_q;
      case (state_q)
         IDLE:     if (accept && is_mul) state_d = MUL_BUSY;
         MUL_BUSY: if (mul_done)         state_d = IDLE;
         default:                        state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      is_sub     = (op == OP_SUB);
      b_eff      = is_sub ? ~b : b;
      sum        = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
      shamt      = SW'(b % WIDTH_V);
      sc_result  = '0;
      sc_illegal = 1'b0;
      sc_flags   = '0;
      case (op)
         OP_ADD, OP_SUB: begin
            sc_result  = sum[WIDTH-1:0];
            sc_flags.c = sum[WIDTH];
            sc_flags.v = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  sc_result = a & b;
         OP_OR:   sc_result = a | b;
         OP_XOR:  sc_result = a ^ b;
         OP_SLL:  sc_result = a << shamt;
         OP_SRL:  sc_result = a >> shamt;
         OP_SRA:  sc_result = $signed(a) >>> shamt;
         OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, a < b};
         OP_MUL:  sc_illegal = !MUL_EN;
         default: sc_illegal = !op_defined(op) || 1'b1;
      endcase
      sc_flags.z = (sc_result == '0);
      sc_flags.n = sc_result[WIDTH-1];
   end

   generate
      if (MUL_EN) begin : g_mul
         alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (accept && is_mul),
            .kill    (flush),
            .a       (a),
            .b       (b),
            .done    (mul_done),
            .product (mul_product)
         );
      end else begin : g_no_mul
         assign mul_done    = 1'b0;
         assign mul_product = '0;
      end
   endgenerate

   // A MUL can only finish with the output register empty: it was accepted with the
   // previous result retiring, and nothing else loads while it is busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         flags_q   <= '0;
         illegal   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept && !is_mul) begin
         out_valid <= 1'b1;
         result    <= sc_result;
         flags_q   <= sc_flags;
         illegal   <= sc_illegal;
      end else if (mul_done) begin
         out_valid <= 1'b1;
         result    <= mul_product;
         flags_q   <= '{z: (mul_product == '0), n: mul_product[WIDTH-1], c: 1'b0, v: 1'b0};
         illegal   <= 1'b0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign flag_z = flags_q.z;
   assign flag_n = flags_q.n;
   assign flag_c = flags_q.c;
   assign flag_v = flags_q.v;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: arithmetic flags, throughput, MUL latency, backpressure, flush, reset.
module tb_alu_pipe;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [3:0]  op;
   logic [31:0] a, b;
   logic        out_ready;

   logic        in_ready, out_valid, flag_z, flag_n, flag_c, flag_v, illegal;
   logic [31:0] result;

   logic        nm_in_ready, nm_out_valid, nm_z, nm_n, nm_c, nm_v, nm_illegal;
   logic [31:0] nm_result;

   int n_tests = 0;
   int n_fail  = 0;
   int seen;

   alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .illegal(illegal)
   );

   alu_pipe #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
      .op(op), .a(a), .b(b), .out_valid(nm_out_valid), .out_ready(out_ready), .result(nm_result),
      .flag_z(nm_z), .flag_n(nm_n), .flag_c(nm_c), .flag_v(nm_v), .illegal(nm_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      in_valid = v;
      op       = o;
      a        = x;
      b        = y;
   endtask

   task automatic check_out(input string tag, input logic [31:0] r, input logic z, input logic n,
                            input logic c, input logic v, input logic il);
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_res"},   result,    r);
      check({tag, "_z"},     flag_z,    z);
      check({tag, "_n"},     flag_n,    n);
      check({tag, "_c"},     flag_c,    c);
      check({tag, "_v"},     flag_v,    v);
      check({tag, "_ill"},   illegal,   il);
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      #1;
      check("rst_valid",  out_valid, 1'b0);
      check("rst_result", result,    32'd0);
      check("rst_flags",  {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
      check("rst_ill",    illegal,   1'b0);
      check("rst_ready",  in_ready,  1'b1);
      repeat (2) tick();
      rst_n = 1'b1;

      // Arithmetic edge cases
      tick();
      drive(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1);
      tick();
      check_out("add_wrap", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 4'd0, 32'h7FFF_FFFF, 32'd1);
      tick();
      check_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 4'd1, 32'd5, 32'd7);
      tick();
      check_out("sub_neg", 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Back-to-back logic, shifts and compares
      drive(1'b1, 4'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F);
      tick();
      check_out("and", 32'h00F0_000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("b2b_ready", in_ready, 1'b1);
      drive(1'b1, 4'd4, 32'hFFFF_0000, 32'hFF00_FF00);
      tick();
      check_out("xor", 32'h00FF_FF00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'd5, 32'd1, 32'd35);
      tick();
      check_out("sll_mod", 32'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'd7, 32'h8000_0000, 32'd4);
      tick();
      check_out("sra", 32'hF800_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'd6, 32'h8000_0000, 32'd31);
      tick();
      check_out("srl", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'd8, 32'hFFFF_FFFF, 32'd1);
      tick();
      check_out("slt", 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'd9, 32'hFFFF_FFFF, 32'd1);
      tick();
      check_out("sltu", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 4'd3, 32'h0000_1200, 32'h0000_0034);
      tick();
      check_out("or", 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      tick();
      check("retire_idle", out_valid, 1'b0);

      // MUL latency; the MUL_EN=0 instance must flag the same opcode illegal
      drive(1'b1, 4'd10, 32'd1234, 32'd5678);
      #1 check("mul_accept_ready", in_ready, 1'b1);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      check("nomul_valid",  nm_out_valid, 1'b1);
      check("nomul_ill",    nm_illegal,   1'b1);
      check("nomul_result", nm_result,    32'd0);
      check("nomul_z",      nm_z,         1'b1);
      for (int i = 1; i <= 31; i++) begin
         check("mul_busy_ready", in_ready,  1'b0);
         check("mul_busy_valid", out_valid, 1'b0);
         tick();
      end
      check_out("mul", 32'd7006652, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("mul_done_ready", in_ready, 1'b1);
      tick();
      check("mul_retired", out_valid, 1'b0);

      // Backpressure: hold the ADD result, then retire and accept in one cycle
      out_ready = 1'b0;
      drive(1'b1, 4'd0, 32'd10, 32'd20);
      tick();
      drive(1'b1, 4'd1, 32'd100, 32'd1);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", out_valid, 1'b1);
         check("bp_res",   result,    32'd30);
         check("bp_flags", {flag_z, flag_n, flag_c, flag_v}, 4'b0000);
         check("bp_ready", in_ready,  1'b0);
         tick();
      end
      out_ready = 1'b1;
      #1 check("bp_release_ready", in_ready, 1'b1);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      check_out("bp_sub", 32'd99, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      check("bp_retired", out_valid, 1'b0);

      // flush beats retirement of a held result
      out_ready = 1'b0;
      drive(1'b1, 4'd0, 32'd2, 32'd2);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      check("fr_valid", out_valid, 1'b1);
      check("fr_res",   result,    32'd4);
      flush     = 1'b1;
      out_ready = 1'b1;
      #1 check("fr_ready", in_ready, 1'b0);
      tick();
      flush = 1'b0;
      check("fr_killed", out_valid, 1'b0);

      // flush at cycle 10 of a MUL, with a competing request
      drive(1'b1, 4'd10, 32'd3, 32'd4);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      repeat (9) tick();
      flush = 1'b1;
      drive(1'b1, 4'd0, 32'd1, 32'd1);
      #1 check("fm_ready", in_ready, 1'b0);
      tick();
      flush = 1'b0;
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      check("fm_valid", out_valid, 1'b0);
      #1 check("fm_idle_ready", in_ready, 1'b1);
      seen = 0;
      repeat (40) begin
         tick();
         if (out_valid) seen++;
      end
      check("fm_no_out", seen, 0);

      // Reset mid-MUL
      drive(1'b1, 4'd10, 32'd3, 32'd4);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      check("rm_valid", out_valid, 1'b0);
      check("rm_ready", in_ready,  1'b1);
      tick();
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         tick();
         if (out_valid) seen++;
      end
      check("rm_no_out", seen, 0);

      // A fresh MUL after the aborts still takes the full latency
      drive(1'b1, 4'd10, 32'd3, 32'd4);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      check("mul2_busy", in_ready, 1'b0);
      repeat (31) tick();
      check_out("mul2", 32'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Undefined opcode, accepted while the MUL result retires
      drive(1'b1, 4'hF, 32'h1234_5678, 32'h9ABC_DEF0);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      check_out("illegal", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
